irq_pending_ctrl: RTL and testbench

Interrupt-request front end for the priority encoder path. Captures N asynchronous-to-software request lines into a sticky pending register and selects the highest-index unmasked pending line through an N-to-log2(N) priority encoder. Presents the result to the consumer with a valid/ack handshake and clears the served bit. Sits directly upstream of the interrupt consumer and wraps the combinational encoder as its selection stage.

---
 rtl/irq_pkg.sv | 12 +
 rtl/prio_enc_n.sv | 22 ++
 rtl/irq_pending_ctrl.sv | 116 +++++++++++
 tb/tb_irq_pending_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared types and defaults for the interrupt pending/presentation front end.
package irq_pkg;

    localparam int unsigned N_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        GAP     = 2'd2
    } state_t;

endpackage

// File: rtl/prio_enc_n.sv
// N-to-log2(N) priority encoder; the highest set index wins, any flags a non-zero input.
module prio_enc_n #(
    parameter  int unsigned N     = 4,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Ascending scan so the last (highest) set bit overrides lower ones.
    always_comb begin
        idx = '0;
        any = |req_vec;
        for (int i = 0; i < N; i++) begin
            if (req_vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Sticky interrupt pending register with highest-index selection and a valid/ack handshake.
// Define IRQ_EDGE_DETECT_EN to pend on rising edges of req instead of on its level.
module irq_pending_ctrl
    import irq_pkg::*;
#(
    parameter  int unsigned N     = N_DEFAULT,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     mask,
    output logic             irq_valid,
    output logic [IDX_W-1:0] irq_id,
    input  logic             irq_ack,
    output logic [N-1:0]     pending,
    output logic [N-1:0]     overflow,
    input  logic             ovf_clr
);

    state_t             state;
    state_t             state_n;
    logic [N-1:0]       set;
    logic [N-1:0]       clr;
    logic [N-1:0]       cand;
    logic [N-1:0]       pending_n;
    logic [N-1:0]       overflow_n;
    logic               valid_n;
    logic [IDX_W-1:0]   id_n;
    logic [IDX_W-1:0]   enc_id;
    logic               enc_any;

`ifdef IRQ_EDGE_DETECT_EN
    logic [N-1:0] req_q;

    // A line already high when reset releases counts as one rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= '0;
        end else begin
            req_q <= req;
        end
    end

    assign set = req & ~req_q;
`else
    assign set = req;
`endif

    // Only the presented line is cleared, and only on an accepted handshake.
    always_comb begin
        clr = '0;
        for (int i = 0; i < N; i++) begin
            if (irq_ack && irq_valid && (irq_id == IDX_W'(i))) begin
                clr[i] = 1'b1;
            end
        end
    end

    assign pending_n  = set | (pending & ~clr);
    assign overflow_n = (set & pending & ~clr) | (overflow & {N{~ovf_clr}});
    assign cand       = pending & ~mask;

    prio_enc_n #(.N(N)) u_prio_enc (
        .req_vec (cand),
        .idx     (enc_id),
        .any     (enc_any)
    );

    // Presentation FSM: a presented index is held until acked, then one settle cycle.
    always_comb begin
        state_n = state;
        valid_n = irq_valid;
        id_n    = irq_id;
        case (state)
            IDLE: begin
                if (enc_any) begin
                    state_n = PRESENT;
                    valid_n = 1'b1;
                    id_n    = enc_id;
                end
            end
            PRESENT: begin
                if (irq_ack) begin
                    state_n = GAP;
                    valid_n = 1'b0;
                end
            end
            GAP: begin
                state_n = IDLE;
                valid_n = 1'b0;
            end
            default: begin
                state_n = IDLE;
                valid_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            irq_valid <= 1'b0;
            irq_id    <= '0;
            pending   <= '0;
            overflow  <= '0;
        end else begin
            state     <= state_n;
            irq_valid <= valid_n;
            irq_id    <= id_n;
            pending   <= pending_n;
            overflow  <= overflow_n;
        end
    end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Scoreboard bench for irq_pending_ctrl: directed scenarios then random traffic vs a rule-level model.
module tb_irq_pending_ctrl;

    localparam int unsigned N     = 4;
    localparam int unsigned IDX_W = $clog2(N);

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req;
    logic [N-1:0]     mask;
    logic             irq_valid;
    logic [IDX_W-1:0] irq_id;
    logic             irq_ack;
    logic [N-1:0]     pending;
    logic [N-1:0]     overflow;
    logic             ovf_clr;

    irq_pending_ctrl #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .mask      (mask),
        .irq_valid (irq_valid),
        .irq_id    (irq_id),
        .irq_ack   (irq_ack),
        .pending   (pending),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int presentations = 0;
    int exp_q[$];

    // Reference model state, expressed as the rules of the block rather than its registers.
    bit m_pend[N];
    bit m_ovf[N];
    bit m_reqq[N];
    bit m_valid;
    bit m_gap;
    int m_id;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] pack(input bit v[N]);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = v[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0;
            m_ovf[i]  = 0;
            m_reqq[i] = 0;
        end
        m_valid = 0;
        m_gap   = 0;
        m_id    = 0;
        exp_q.delete();
    endtask

    // One clock: check model vs DUT at the falling edge, drive inputs, advance model across the next rise.
    task automatic step(input logic [N-1:0] r, input logic [N-1:0] mk, input logic a, input logic oc);
        int  clr_id;
        int  best;
        bit  setv[N];
        bit  stay;
        @(negedge clk);
        check("pending", pending, pack(m_pend));
        check("overflow", overflow, pack(m_ovf));
        check("irq_valid", irq_valid, m_valid);
        check("irq_id_hold", irq_id, m_id);
        req     = r;
        mask    = mk;
        irq_ack = a;
        ovf_clr = oc;

        clr_id = (a && m_valid) ? m_id : -1;
        for (int i = 0; i < N; i++) begin
`ifdef IRQ_EDGE_DETECT_EN
            setv[i]   = r[i] && !m_reqq[i];
`else
            setv[i]   = r[i];
`endif
            m_reqq[i] = r[i];
        end
        best = -1;
        for (int i = N - 1; i >= 0; i--) begin
            if (m_pend[i] && !mk[i]) begin
                best = i;
                break;
            end
        end
        for (int i = 0; i < N; i++) begin
            stay = m_pend[i] && (i != clr_id);
            if (setv[i] && stay) m_ovf[i] = 1;
            else if (oc)         m_ovf[i] = 0;
            m_pend[i] = setv[i] || stay;
        end
        if (m_valid) begin
            if (a) begin
                m_valid = 0;
                m_gap   = 1;
            end
        end else if (m_gap) begin
            m_gap = 0;
        end else if (best >= 0) begin
            m_valid = 1;
            m_id    = best;
            exp_q.push_back(best);
        end
    endtask

    // Monitor: each new presentation pops the expected index; an ongoing one must not change.
    initial begin
        logic prev_valid;
        int   cur;
        prev_valid = 1'b0;
        cur        = 0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && irq_valid === 1'b1 && !prev_valid) begin
                presentations++;
                if (exp_q.size() == 0) begin
                    check("unexpected_presentation", 32'd1, 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    check("presented_id", irq_id, cur);
                end
            end else if (irq_valid === 1'b1 && prev_valid) begin
                check("id_stable", irq_id, cur);
            end
            prev_valid = (irq_valid === 1'b1);
        end
    end

    initial begin
        int p0;
        rst_n   = 1'b0;
        req     = '0;
        mask    = '0;
        irq_ack = 1'b0;
        ovf_clr = 1'b0;
        model_reset();
        #12;
        check("rst_valid", irq_valid, 0);
        check("rst_id", irq_id, 0);
        check("rst_pending", pending, 0);
        check("rst_overflow", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-presentation with 1010 pending.
        step(4'b1010, 4'b0000, 0, 0);
        step(4'b0000, 4'b0000, 0, 0);
        step(4'b0000, 4'b0000, 0, 0);
        #2;
        check("pre_rst_pending", pending, 4'b1010);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", irq_valid, 0);
        check("async_rst_pending", pending, 0);
        check("async_rst_id", irq_id, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b0000, 4'b0000, 1, 0);
        step(4'b0000, 4'b0000, 0, 0);

        // Single request, 2-cycle latency, ack, then quiet.
        step(4'b0100, 4'b0000, 0, 0);
        step(4'b0000, 4'b0000, 0, 0);
        step(4'b0000, 4'b0000, 0, 0);
        check("single_id", irq_id, 2);
        step(4'b0000, 4'b0000, 1, 0);
        for (int k = 0; k < 4; k++) step(4'b0000, 4'b0000, 0, 0);

        // No preemption: id 0 presented, line 3 arrives, 3 only after ack and gap.
        step(4'b0001, 4'b0000, 0, 0);
        step(4'b0000, 4'b0000, 0, 0);
        step(4'b1000, 4'b0000, 0, 0);
        step(4'b0000, 4'b0000, 0, 0);
        step(4'b0000, 4'b0000, 0, 0);
        check("nopreempt_id", irq_id, 0);
        step(4'b0000, 4'b0000, 1, 0);
        for (int k = 0; k < 3; k++) step(4'b0000, 4'b0000, 0, 0);
        check("after_gap_id", irq_id, 3);
        step(4'b0000, 4'b0000, 1, 0);
        step(4'b0000, 4'b0000, 0, 0);

        // Mask: 0110 pending with line 2 masked presents 1, then 2 after unmask.
        step(4'b0110, 4'b0100, 0, 0);
        step(4'b0000, 4'b0100, 0, 0);
        step(4'b0000, 4'b0100, 0, 0);
        check("mask_id", irq_id, 1);
        step(4'b0000, 4'b0000, 1, 0);
        for (int k = 0; k < 3; k++) step(4'b0000, 4'b0000, 0, 0);
        step(4'b0000, 4'b0000, 1, 0);
        step(4'b0000, 4'b0000, 0, 0);

`ifdef IRQ_EDGE_DETECT_EN
        // Held request pends once; one presentation, no overflow.
        p0 = presentations;
        for (int k = 0; k < 10; k++) step(4'b0010, 4'b0000, (k == 4), 0);
        for (int k = 0; k < 4; k++) step(4'b0000, 4'b0000, 0, 0);
        check("edge_one_presentation", presentations - p0, 1);
        check("edge_overflow", overflow, 0);
`else
        // Held level request flags overflow; ovf_clr clears it once req drops.
        p0 = presentations;
        for (int k = 0; k < 4; k++) step(4'b1000, 4'b0000, 0, 0);
        step(4'b0000, 4'b0000, 0, 0);
        check("level_overflow", overflow, 4'b1000);
        step(4'b0000, 4'b0000, 0, 1);
        step(4'b0000, 4'b0000, 1, 0);
        step(4'b0000, 4'b0000, 0, 0);
        check("ovf_cleared", overflow, 0);
        check("level_one_presentation", presentations - p0, 1);
`endif
        for (int k = 0; k < 3; k++) step(4'b0000, 4'b0000, 1, 0);

        // Random traffic.
        for (int k = 0; k < 600; k++) begin
            logic [N-1:0] r;
            logic [N-1:0] mk;
            for (int i = 0; i < N; i++) r[i] = ($urandom_range(0, 4) == 0);
            mk = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
            step(r, mk, 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
        end

        // Drain: everything pending must get presented and acked.
        for (int k = 0; k < 20; k++) step(4'b0000, 4'b0000, 1, 1);
        @(negedge clk);
        check("drain_pending", pending, 0);
        check("drain_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
